cj_cosim_checker: RTL and testbench

Co-simulation checker for the CJ fuzzing flow. It sits beside the SoC test harness and compares each committed DUT instruction against a reference-model commit stream. It snoops the program's tohost store and raises a 64-bit `tohost` status word: bit 0 set means the round is finished, following the riscv-tests convention (1 = pass, `(code<<1)|1` = fail).

---
 rtl/cj_pkg.sv | 18 +
 rtl/cj_ref_fifo.sv | 53 +++++
 rtl/cj_cosim_checker.sv | 85 ++++++++
 tb/tb_cj_cosim_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cj_pkg.sv
// Shared types and status encodings for the CJ co-simulation checker.
package cj_pkg;

  localparam logic [1:0] CJ_CODE_MISMATCH  = 2'd1;
  localparam logic [1:0] CJ_CODE_TIMEOUT   = 2'd2;
  localparam logic [1:0] CJ_CODE_UNDERFLOW = 2'd3;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } cj_commit_t;

  // riscv-tests style failure word: code shifted up with the finished bit set.
  function automatic logic [63:0] fail_word(input logic [1:0] code);
    return {61'd0, code, 1'b1};
  endfunction

endpackage

// File: rtl/cj_ref_fifo.sv
// Synchronous FIFO holding reference-model commits until the DUT retires them.
module cj_ref_fifo
  import cj_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       push_i,
  input  cj_commit_t push_data_i,
  input  logic       pop_i,
  output cj_commit_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  cj_commit_t     mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;

  // The extra pointer bit separates full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/cj_cosim_checker.sv
// Compares DUT retirements against a buffered reference commit stream and
// maintains the riscv-tests style tohost status word.
module cj_cosim_checker
  import cj_pkg::*;
#(
  parameter logic [63:0] TOHOST_ADDR    = 64'h8000_1000,
  parameter logic [63:0] TIMEOUT_CYCLES = 64'd2_000_000_000,
  parameter int          REF_DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dut_commit_valid,
  input  logic [63:0] dut_commit_pc,
  input  logic [31:0] dut_commit_inst,
  input  logic        ref_commit_valid,
  output logic        ref_commit_ready,
  input  logic [63:0] ref_commit_pc,
  input  logic [31:0] ref_commit_inst,
  input  logic        mem_wr_valid,
  input  logic [63:0] mem_wr_addr,
  input  logic [63:0] mem_wr_data,
  input  logic        host_set_valid,
  input  logic [63:0] host_set_value,
  output logic [63:0] tohost,
  output logic        done
);

  logic [63:0] tohost_q, tohost_d;
  logic [63:0] cnt_q, cnt_d;
  cj_commit_t  ref_c, dut_c, head;
  logic        fifo_full, fifo_empty;
  logic        push, pop, mismatch, underflow, pass_store, timeout;

  assign done             = tohost_q[0];
  assign tohost           = tohost_q;
  assign ref_commit_ready = !fifo_full && !done;

  assign ref_c = '{pc: ref_commit_pc, inst: ref_commit_inst};
  assign dut_c = '{pc: dut_commit_pc, inst: dut_commit_inst};

  // Every checking event is gated by !done so the round freezes once finished.
  assign push       = ref_commit_valid && ref_commit_ready;
  assign pop        = dut_commit_valid && !fifo_empty && !done;
  assign mismatch   = pop && (head != dut_c);
  assign underflow  = dut_commit_valid && fifo_empty && !done;
  assign pass_store = mem_wr_valid && (mem_wr_addr == TOHOST_ADDR) &&
                      mem_wr_data[0] && !done;
  assign timeout    = !done && (cnt_q == TIMEOUT_CYCLES - 64'd1);

  cj_ref_fifo #(
    .DEPTH (REF_DEPTH)
  ) u_fifo (
    .clock_i     (clock),
    .reset_ni    (reset),
    .push_i      (push),
    .push_data_i (ref_c),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    tohost_d = tohost_q;
    cnt_d    = cnt_q;
    if (host_set_valid)  tohost_d = host_set_value;
    else if (pass_store) tohost_d = mem_wr_data;
    else if (mismatch)   tohost_d = fail_word(CJ_CODE_MISMATCH);
    else if (underflow)  tohost_d = fail_word(CJ_CODE_UNDERFLOW);
    else if (timeout)    tohost_d = fail_word(CJ_CODE_TIMEOUT);
    if (!done && (cnt_q != '1)) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tohost_q <= '0;
      cnt_q    <= '0;
    end else begin
      tohost_q <= tohost_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cj_cosim_checker.sv
// Directed self-checking bench for cj_cosim_checker.
module tb_cj_cosim_checker;

  localparam logic [63:0] TOHOST = 64'h8000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        dut_commit_valid;
  logic [63:0] dut_commit_pc;
  logic [31:0] dut_commit_inst;
  logic        ref_commit_valid;
  logic        ref_commit_ready;
  logic [63:0] ref_commit_pc;
  logic [31:0] ref_commit_inst;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        host_set_valid;
  logic [63:0] host_set_value;
  logic [63:0] tohost;
  logic        done;

  // Idle-input instance with a short cycle budget for the timeout case.
  logic        to_ready;
  logic [63:0] to_tohost;
  logic        to_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  cj_cosim_checker #(
    .TOHOST_ADDR    (TOHOST),
    .TIMEOUT_CYCLES (64'd1000),
    .REF_DEPTH      (4)
  ) u_dut (
    .clock            (clock),
    .reset            (reset),
    .dut_commit_valid (dut_commit_valid),
    .dut_commit_pc    (dut_commit_pc),
    .dut_commit_inst  (dut_commit_inst),
    .ref_commit_valid (ref_commit_valid),
    .ref_commit_ready (ref_commit_ready),
    .ref_commit_pc    (ref_commit_pc),
    .ref_commit_inst  (ref_commit_inst),
    .mem_wr_valid     (mem_wr_valid),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data),
    .host_set_valid   (host_set_valid),
    .host_set_value   (host_set_value),
    .tohost           (tohost),
    .done             (done)
  );

  cj_cosim_checker #(
    .TOHOST_ADDR    (TOHOST),
    .TIMEOUT_CYCLES (64'd16),
    .REF_DEPTH      (4)
  ) u_to (
    .clock            (clock),
    .reset            (reset),
    .dut_commit_valid (1'b0),
    .dut_commit_pc    (64'd0),
    .dut_commit_inst  (32'd0),
    .ref_commit_valid (1'b0),
    .ref_commit_ready (to_ready),
    .ref_commit_pc    (64'd0),
    .ref_commit_inst  (32'd0),
    .mem_wr_valid     (1'b0),
    .mem_wr_addr      (64'd0),
    .mem_wr_data      (64'd0),
    .host_set_valid   (1'b0),
    .host_set_value   (64'd0),
    .tohost           (to_tohost),
    .done             (to_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dut_commit_valid = 1'b0;
    dut_commit_pc    = '0;
    dut_commit_inst  = '0;
    ref_commit_valid = 1'b0;
    ref_commit_pc    = '0;
    ref_commit_inst  = '0;
    mem_wr_valid     = 1'b0;
    mem_wr_addr      = '0;
    mem_wr_data      = '0;
    host_set_valid   = 1'b0;
    host_set_value   = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push_ref(input logic [63:0] pc, input logic [31:0] inst);
    ref_commit_valid = 1'b1;
    ref_commit_pc    = pc;
    ref_commit_inst  = inst;
    tick();
    ref_commit_valid = 1'b0;
  endtask

  task automatic dut_commit(input logic [63:0] pc, input logic [31:0] inst);
    dut_commit_valid = 1'b1;
    dut_commit_pc    = pc;
    dut_commit_inst  = inst;
    tick();
    dut_commit_valid = 1'b0;
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] data);
    mem_wr_valid = 1'b1;
    mem_wr_addr  = addr;
    mem_wr_data  = data;
    tick();
    mem_wr_valid = 1'b0;
  endtask

  task automatic host_set(input logic [63:0] value);
    host_set_valid = 1'b1;
    host_set_value = value;
    tick();
    host_set_valid = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b0;

    // Reset state and a clean passing round.
    do_reset();
    check("rst_tohost", tohost, 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(ref_commit_ready), 64'd1);
    for (int i = 0; i < 3; i++) push_ref(64'h8000_0000 + 64'(4 * i), 32'h13);
    check("push3_ready", 64'(ref_commit_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      dut_commit(64'h8000_0000 + 64'(4 * i), 32'h13);
      check("match_tohost", tohost, 64'd0);
    end
    store(TOHOST, 64'd2);
    check("store_bit0_clear", tohost, 64'd0);
    store(TOHOST + 64'd8, 64'd1);
    check("store_other_addr", tohost, 64'd0);
    store(TOHOST, 64'd1);
    check("pass_tohost", tohost, 64'd1);
    check("pass_done", 64'(done), 64'd1);
    check("pass_fifo_empty", 64'(u_dut.fifo_empty), 64'd1);
    check("pass_ready", 64'(ref_commit_ready), 64'd0);

    // PC mismatch, then everything afterwards is ignored.
    do_reset();
    push_ref(64'h8000_0010, 32'h13);
    dut_commit(64'h8000_0014, 32'h13);
    check("pc_mismatch", tohost, 64'd3);
    ref_commit_valid = 1'b1;
    ref_commit_pc    = 64'h8000_0018;
    dut_commit_valid = 1'b1;
    dut_commit_pc    = 64'h8000_0010;
    mem_wr_valid     = 1'b1;
    mem_wr_addr      = TOHOST;
    mem_wr_data      = 64'd1;
    tick();
    idle();
    check("sticky_after_mismatch", tohost, 64'd3);
    check("sticky_ready", 64'(ref_commit_ready), 64'd0);

    // Instruction-word mismatch with matching PC.
    do_reset();
    push_ref(64'h8000_0020, 32'h0000_0013);
    dut_commit(64'h8000_0020, 32'h0000_0033);
    check("inst_mismatch", tohost, 64'd3);

    // Underflow even with a same-cycle reference push.
    do_reset();
    ref_commit_valid = 1'b1;
    ref_commit_pc    = 64'h8000_0040;
    ref_commit_inst  = 32'h13;
    dut_commit_valid = 1'b1;
    dut_commit_pc    = 64'h8000_0040;
    dut_commit_inst  = 32'h13;
    tick();
    idle();
    check("underflow_tohost", tohost, 64'd7);
    check("underflow_done", 64'(done), 64'd1);

    // Timeout: fires exactly 16 edges after reset release.
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    check("timeout_before", to_tohost, 64'd0);
    tick();
    check("timeout_fire", to_tohost, 64'd5);
    check("timeout_done", 64'(to_done), 64'd1);

    // Fill, rejected push when full, then steady push+pop across pointer wrap.
    do_reset();
    for (int i = 0; i < 4; i++) push_ref(64'h100 + 64'(4 * i), 32'h0010_0093 + 32'(i));
    check("full_ready", 64'(ref_commit_ready), 64'd0);
    push_ref(64'hdead, 32'h0);
    dut_commit(64'h100, 32'h0010_0093);
    check("after_pop_ready", 64'(ref_commit_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      ref_commit_valid = 1'b1;
      ref_commit_pc    = 64'h100 + 64'(4 * (k + 4));
      ref_commit_inst  = 32'h0010_0093 + 32'(k + 4);
      dut_commit_valid = 1'b1;
      dut_commit_pc    = 64'h100 + 64'(4 * (k + 1));
      dut_commit_inst  = 32'h0010_0093 + 32'(k + 1);
      tick();
      idle();
      check("wrap_tohost", tohost, 64'd0);
      check("wrap_ready", 64'(ref_commit_ready), 64'd1);
    end
    for (int j = 9; j < 12; j++) dut_commit(64'h100 + 64'(4 * j), 32'h0010_0093 + 32'(j));
    check("drain_tohost", tohost, 64'd0);
    check("drain_empty", 64'(u_dut.fifo_empty), 64'd1);

    // Host set wins over a same-cycle mismatch and pass store; reset clears it.
    do_reset();
    push_ref(64'h200, 32'h13);
    host_set_valid   = 1'b1;
    host_set_value   = 64'd5;
    dut_commit_valid = 1'b1;
    dut_commit_pc    = 64'h204;
    dut_commit_inst  = 32'h13;
    mem_wr_valid     = 1'b1;
    mem_wr_addr      = TOHOST;
    mem_wr_data      = 64'd1;
    tick();
    idle();
    check("host_priority", tohost, 64'd5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midround_rst_tohost", tohost, 64'd0);
    check("midround_rst_done", 64'(done), 64'd0);
    check("midround_rst_ready", 64'(ref_commit_ready), 64'd1);

    // Host clearing bit 0 restarts checking.
    store(TOHOST, 64'h0000_0000_0000_0001);
    check("restart_pass", tohost, 64'd1);
    host_set(64'd0);
    check("restart_clear", 64'(done), 64'd0);
    dut_commit(64'h300, 32'h13);
    check("restart_underflow", tohost, 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
